// File: rtl/unalign8_wr.sv
// unalign8_wr: packs a stream of aligned 64-bit words (1..8 valid low bytes each)
// into a contiguous byte string in 64-bit memory starting at any byte address.
// Emits word-addressed writes with byte enables and flushes the trailing partial word.
module unalign8_wr #(
  parameter int unsigned ADDR_MSB = 7
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [ADDR_MSB:0]   dst_addr,
  input  logic                wr_en,
  input  logic [63:0]         din,
  input  logic [3:0]          len,
  input  logic                last,
  output logic                ready,
  output logic                busy,
  output logic                mem_wr_en,
  output logic [ADDR_MSB-3:0] mem_addr,
  output logic [63:0]         mem_din,
  output logic [7:0]          mem_be,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          p_q, p_d;
  logic [63:0]         stg_q, stg_d;
  logic [7:0]          stg_be_q, stg_be_d;
  logic [ADDR_MSB-3:0] waddr_q, waddr_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_MSB-3:0] mem_addr_q, mem_addr_d;
  logic [63:0]         mem_din_q, mem_din_d;
  logic [7:0]          mem_be_q, mem_be_d;
  logic                err_q, err_d;

  logic         len_ok, wr_acc, wr_err, start_err;
  logic [3:0]   sum;
  logic [7:0]   len_mask;
  logic [15:0]  be16;
  logic [127:0] shifted, mask128;
  logic [63:0]  lo_data;
  logic [7:0]   lo_be;

  // Place the new bytes at their output positions across the current and next word
  always_comb begin
    len_ok    = (len != 4'd0) && (len <= 4'd8);
    wr_acc    = wr_en && (state_q == RUN) && len_ok;
    wr_err    = wr_en && ((state_q != RUN) || !len_ok);
    start_err = start && (state_q != IDLE);
    sum       = {1'b0, p_q} + len;
    len_mask  = 8'hFF >> (4'd8 - len);
    be16      = {8'd0, len_mask} << p_q;
    shifted   = {64'd0, din} << {p_q, 3'b000};
    mask128   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      mask128[8*i +: 8] = {8{be16[i]}};
    end
    shifted   = shifted & mask128;
    lo_data   = (stg_q & ~mask128[63:0]) | shifted[63:0];
    lo_be     = stg_be_q | be16[7:0];
  end

  // Next-state, staging and registered-output computation
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    stg_d       = stg_q;
    stg_be_d    = stg_be_q;
    waddr_d     = waddr_q;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_be_d    = mem_be_q;
    err_d       = err_q | start_err | wr_err;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          p_d      = dst_addr[2:0];
          waddr_d  = dst_addr[ADDR_MSB:3];
          stg_be_d = '0;
        end
      end
      RUN: begin
        if (wr_acc) begin
          p_d = sum[2:0];
          if (sum[3]) begin
            mem_wr_en_d = 1'b1;
            mem_addr_d  = waddr_q;
            mem_din_d   = lo_data;
            mem_be_d    = lo_be;
            stg_d       = shifted[127:64];
            stg_be_d    = be16[15:8];
            waddr_d     = waddr_q + 1'b1;
          end else begin
            stg_d    = lo_data;
            stg_be_d = lo_be;
          end
          if (last) begin
            state_d = (stg_be_d != 8'd0) ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        mem_wr_en_d = 1'b1;
        mem_addr_d  = waddr_q;
        mem_din_d   = stg_q;
        mem_be_d    = stg_be_q;
        stg_be_d    = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      p_q         <= '0;
      stg_q       <= '0;
      stg_be_q    <= '0;
      waddr_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      stg_q       <= stg_d;
      stg_be_q    <= stg_be_d;
      waddr_q     <= waddr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_be_q    <= mem_be_d;
      err_q       <= err_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_be    = mem_be_q;
  assign err       = err_q;

endmodule

// File: tb/tb_unalign8_wr.sv
// Testbench for unalign8_wr: byte-address reference model feeds a write scoreboard,
// plus directed timing checks for the documented scenarios.
module tb_unalign8_wr;
  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned AW = ADDR_MSB - 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    be;
    logic [63:0]   data;
  } wr_t;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic [ADDR_MSB:0] dst_addr = '0;
  logic            wr_en = 1'b0;
  logic [63:0]     din = '0;
  logic [3:0]      len = '0;
  logic            last = 1'b0;
  logic            ready, busy, mem_wr_en, err;
  logic [AW-1:0]   mem_addr;
  logic [63:0]     mem_din;
  logic [7:0]      mem_be;

  int   total = 0;
  int   bad = 0;
  wr_t  exp_q[$];
  logic [7:0] bytes_q[$];

  unalign8_wr #(.ADDR_MSB(ADDR_MSB)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .dst_addr(dst_addr),
    .wr_en(wr_en), .din(din), .len(len), .last(last),
    .ready(ready), .busy(busy), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Scoreboard monitor: every write strobe pops and checks the oldest expected write
  always @(negedge CLK) begin
    if (RST_N && mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_be", 64'(mem_be), 64'(e.be));
        chk("wr_data", mem_din & bmask(e.be), e.data);
      end
    end
  end

  // Reference: lay the byte stream out at consecutive byte addresses and
  // produce one write per touched word, in address order (at most nmax writes).
  task automatic model_push(input int unsigned a, input int unsigned nmax);
    wr_t w;
    bit  open;
    int unsigned cnt, ba, wa, pos;
    open = 0;
    cnt = 0;
    w = '0;
    for (int k = 0; k < bytes_q.size(); k++) begin
      ba  = a + k;
      wa  = (ba >> 3) % (1 << AW);
      pos = ba % 8;
      if (open && wa != w.addr) begin
        if (cnt < nmax) exp_q.push_back(w);
        cnt++;
        open = 0;
      end
      if (!open) begin
        w = '0;
        w.addr = AW'(wa);
        open = 1;
      end
      w.be[pos] = 1'b1;
      w.data[8*pos +: 8] = bytes_q[k];
    end
    if (open && cnt < nmax) exp_q.push_back(w);
    bytes_q.delete();
  endtask

  task automatic add_word(input logic [63:0] d, input int unsigned l);
    for (int unsigned i = 0; i < l; i++) bytes_q.push_back(d[8*i +: 8]);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_MSB:0] a);
    dst_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] l, input logic lst);
    din = d;
    len = l;
    last = lst;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    last = 1'b0;
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_din"}, mem_din, 64'd0);
    chk({tag, "_be"}, 64'(mem_be), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [63:0] wd[6];
    int unsigned wl[6];
    int unsigned a, nw;

    tick();
    tick();
    chk_reset_outputs("rst");
    RST_N = 1'b1;
    tick();

    // 1: aligned, back-to-back
    add_word(64'h0706050403020100, 8);
    add_word(64'h0F0E0D0C0B0A0908, 8);
    model_push(32'h10, 99);
    do_start(8'h10);
    chk("t1_ready", 64'(ready), 64'd1);
    send(64'h0706050403020100, 4'd8, 1'b0);
    chk("t1_w0_en", 64'(mem_wr_en), 64'd1);
    chk("t1_w0_addr", 64'(mem_addr), 64'd2);
    chk("t1_w0_data", mem_din, 64'h0706050403020100);
    send(64'h0F0E0D0C0B0A0908, 4'd8, 1'b1);
    chk("t1_w1_en", 64'(mem_wr_en), 64'd1);
    chk("t1_w1_addr", 64'(mem_addr), 64'd3);
    chk("t1_w1_be", 64'(mem_be), 64'hFF);
    tick();
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_noflush", 64'(mem_wr_en), 64'd0);

    // 2: unaligned single word with flush
    add_word(64'h0807060504030201, 8);
    model_push(32'h03, 99);
    do_start(8'h03);
    send(64'h0807060504030201, 4'd8, 1'b1);
    chk("t2_en", 64'(mem_wr_en), 64'd1);
    chk("t2_addr", 64'(mem_addr), 64'd0);
    chk("t2_be", 64'(mem_be), 64'hF8);
    chk("t2_data", 64'(mem_din[63:24]), 64'h0504030201);
    chk("t2_busy", 64'(busy), 64'd1);
    tick();
    chk("t2_fl_en", 64'(mem_wr_en), 64'd1);
    chk("t2_fl_addr", 64'(mem_addr), 64'd1);
    chk("t2_fl_be", 64'(mem_be), 64'h07);
    chk("t2_fl_data", 64'(mem_din[23:0]), 64'h080706);
    chk("t2_idle", 64'(busy), 64'd0);
    tick();

    // 3: accumulate three short words into one
    add_word(64'h030201, 3);
    add_word(64'h060504, 3);
    add_word(64'h0807, 2);
    model_push(32'h0, 99);
    do_start(8'h00);
    send(64'h030201, 4'd3, 1'b0);
    chk("t3_nowr0", 64'(mem_wr_en), 64'd0);
    send(64'h060504, 4'd3, 1'b0);
    chk("t3_nowr1", 64'(mem_wr_en), 64'd0);
    send(64'h0807, 4'd2, 1'b1);
    chk("t3_en", 64'(mem_wr_en), 64'd1);
    chk("t3_be", 64'(mem_be), 64'hFF);
    chk("t3_data", mem_din, 64'h0807060504030201);
    chk("t3_busy", 64'(busy), 64'd0);
    tick();
    chk("t3_single", 64'(mem_wr_en), 64'd0);

    // 4: partial word, flush only (upper din bytes are junk)
    add_word(64'hDEADBEEF11AABBCC, 3);
    model_push(32'h02, 99);
    do_start(8'h02);
    send(64'hDEADBEEF11AABBCC, 4'd3, 1'b1);
    chk("t4_nowr", 64'(mem_wr_en), 64'd0);
    tick();
    chk("t4_en", 64'(mem_wr_en), 64'd1);
    chk("t4_be", 64'(mem_be), 64'h1C);
    chk("t4_data", 64'(mem_din[39:16]), 64'hAABBCC);
    tick();

    // 5a: wr_en in IDLE
    send(64'h1, 4'd8, 1'b1);
    chk("t5a_err", 64'(err), 64'd1);
    tick();
    chk("t5a_sticky", 64'(err), 64'd1);
    chk("t5a_nowr", 64'(mem_wr_en), 64'd0);
    do_reset();
    chk("t5a_clr", 64'(err), 64'd0);

    // 5b: len=0 in RUN is ignored, state untouched
    do_start(8'h00);
    send(64'h55, 4'd0, 1'b1);
    chk("t5b_err", 64'(err), 64'd1);
    chk("t5b_nowr", 64'(mem_wr_en), 64'd0);
    chk("t5b_ready", 64'(ready), 64'd1);
    add_word(64'h1122334455667788, 8);
    model_push(32'h0, 99);
    send(64'h1122334455667788, 4'd8, 1'b1);
    chk("t5b_recov", 64'(mem_wr_en), 64'd1);
    tick();
    chk("t5b_sticky", 64'(err), 64'd1);
    do_reset();
    chk("t5b_clr", 64'(err), 64'd0);

    // 5c: start while busy, also start+wr_en together in IDLE
    dst_addr = 8'h00;
    start = 1'b1;
    wr_en = 1'b1;
    len = 4'd8;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("t5c_err_both", 64'(err), 64'd1);
    chk("t5c_ready", 64'(ready), 64'd1);
    chk("t5c_nowr0", 64'(mem_wr_en), 64'd0);
    do_start(8'h40);
    chk("t5c_busy", 64'(busy), 64'd1);
    add_word(64'hA1A2A3A4A5A6A7A8, 8);
    model_push(32'h0, 99);
    send(64'hA1A2A3A4A5A6A7A8, 4'd8, 1'b1);
    chk("t5c_addr", 64'(mem_addr), 64'd0);
    tick();
    chk("t5c_sticky", 64'(err), 64'd1);
    do_reset();
    chk("t5c_clr", 64'(err), 64'd0);

    // 6a: word address wrap
    add_word(64'h0102030405060708, 8);
    add_word(64'h1112131415161718, 8);
    model_push(32'hFC, 99);
    do_start(8'hFC);
    send(64'h0102030405060708, 4'd8, 1'b0);
    chk("t6_a0", 64'(mem_addr), 64'h1F);
    send(64'h1112131415161718, 4'd8, 1'b1);
    chk("t6_a1", 64'(mem_addr), 64'h00);
    tick();
    chk("t6_fl_addr", 64'(mem_addr), 64'h01);
    chk("t6_fl_be", 64'(mem_be), 64'h0F);
    tick();

    // 6b: asynchronous reset mid-transfer discards the partial word
    add_word(64'hCAFEF00DCAFEF00D, 8);
    model_push(32'h05, 1);
    do_start(8'h05);
    send(64'hCAFEF00DCAFEF00D, 4'd8, 1'b0);
    chk("t6b_en", 64'(mem_wr_en), 64'd1);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("t6b_async");
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6b_nowr", 64'(mem_wr_en), 64'd0);
    end
    chk_reset_outputs("t6b_after");

    // Random transfers against the byte-address model
    for (int t = 0; t < 25; t++) begin
      a  = $urandom_range(0, 255);
      nw = $urandom_range(1, 6);
      for (int i = 0; i < int'(nw); i++) begin
        wd[i] = {$urandom, $urandom};
        wl[i] = $urandom_range(1, 8);
        add_word(wd[i], wl[i]);
      end
      model_push(a, 99);
      do_start(a[ADDR_MSB:0]);
      for (int i = 0; i < int'(nw); i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(wd[i], 4'(wl[i]), (i == int'(nw) - 1));
      end
      wait_idle();
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_err", 64'(err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/unalign8_wr.md
# unalign8_wr

Write-side counterpart of the SHA512 unit's input byte realigner. It takes a stream of aligned 64-bit words, each carrying 1..8 valid low-order bytes, and writes them as a contiguous byte string into 64-bit memory starting at any byte address. It produces word-addressed writes with byte enables, carrying residual bytes across words and flushing the final partial word. It sits between the SHA512 result/output path and the 64-bit per-core memory.

## Interface
- ADDR_MSB, 7, MSB of byte address; word address is [ADDR_MSB:3]
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  begin transfer; accepted only in IDLE
- dst_addr  in  ADDR_MSB+1  destination byte address, sampled with start
- wr_en  in  1  din/len/last valid; accepted only when ready=1
- din  in  64  data, byte 0 in [7:0], little-endian
- len  in  4  valid bytes in din, 1..8, taken from din[7:0] upward
- last  in  1  final word of transfer, qualified by wr_en
- ready  out  1  block accepts wr_en this cycle
- busy  out  1  state != IDLE
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_MSB-2  word address
- mem_din  out  64  write data
- mem_be  out  8  byte enables, bit i = mem_din[8i+7:8i]
- err  out  1  sticky protocol error

## Operation
- State registers: state (IDLE/RUN/FLUSH), p[2:0] (next byte position in current output word), stg[63:0] with stg_be[7:0] (staging word), waddr (word address).
- IDLE: ready=0. start → RUN; p ← dst_addr[2:0]; waddr ← dst_addr[ADDR_MSB:3]; stg_be ← 0.
- RUN: ready=1. On accepted word (n=len), bytes 0..n-1 of din go to positions p..p+n-1. Positions ≥8 spill to positions 0..p+n-9 of the next word.
  - p+n ≥ 8: emit stg merged with the new bytes. mem_be = stg_be | mask of new positions <8. Staging ← spilled bytes; stg_be ← mask of bits 0..p+n-9; p ← (p+n)-8; waddr ← waddr+1.
  - p+n < 8: no emit; merge into staging; p ← p+n.
  - last: if staging after the update is non-empty (stg_be≠0), go to FLUSH. Otherwise go to IDLE.
- FLUSH: ready=0. Emit staging word with mask stg_be at waddr; stg_be ← 0; go to IDLE.
- Byte enables outside valid positions are 0. mem_din bytes with be=0 are don't-care but must be deterministic; drive staging contents.
- waddr increments modulo 2^(ADDR_MSB-2). Wrap from all-ones to 0 is silent.
- Errors set err (sticky until reset); the offending input is ignored with no state change:
  - wr_en when ready=0
  - wr_en with len=0 or len>8
  - start when state≠IDLE
- start and wr_en in the same IDLE cycle: start is taken; wr_en is an error.

## Timing
- Reset values: state=IDLE, ready=0, busy=0, mem_wr_en=0, mem_addr=0, mem_din=0, mem_be=0, err=0, p=0, stg=0, stg_be=0.
- RST_N low mid-transfer: everything returns to reset values immediately. The pending partial word is discarded and no write is issued.
- Outputs mem_* are registered.
  - Word accepted at cycle t that causes an emit: mem_wr_en=1 at t+1 for exactly one cycle.
  - FLUSH entered at t+1: flush write appears at t+2.
- ready rises the cycle after start is accepted.
- Throughput: one input word per cycle sustained in RUN, at most one emit per input. The only bubble is the single FLUSH cycle at end of transfer.
- busy falls the cycle after the final emit, or after the last word when no flush is needed. A new start is accepted that cycle.

## Test plan
1. Aligned: start dst_addr=0x10, din0=0x0706050403020100 len=8, din1 len=8 last, back-to-back.
   - Writes at addr 2 and 3, be=FF, data unchanged, one cycle after each input.
   - No FLUSH; busy low 2 cycles after last.
2. Unaligned: start dst_addr=0x03, din=0x0807060504030201 len=8 last.
   - t+1: addr 0, be=F8, mem_din[63:24]=0x0504030201.
   - t+2: FLUSH at addr 1, be=07, mem_din[23:0]=0x080706.
3. Accumulate: dst_addr=0, len 3,3,2 (last), bytes 01..08 in order.
   - No writes after the first two words.
   - After the third: a single write at addr 0, be=FF, data 0x0807060504030201.
4. Partial fits in one word: dst_addr=0x02, len=3 last, din=0x..AABBCC.
   - FLUSH write at addr 0, be=1C, mem_din[39:16]=0xAABBCC.
5. Errors, each followed by a check that err=1 stays set, no mem_wr_en results, and RST_N low clears err:
   - wr_en in IDLE
   - len=0 in RUN
   - start while busy
6. Wrap and reset:
   - ADDR_MSB=7, dst_addr=0xFC, two len-8 words: writes at 0x1F, 0x00, then a flush at 0x01 with be=0F.
   - Separate run: RST_N pulse between words; no further writes occur and all outputs read their reset values.
